// File: rtl/aux_mailbox_if.sv
// Control-side request/response and host-side block-pipe signals of aux_mailbox.
// slave is the mailbox side, master is the side that drives requests and host traffic.
interface aux_mailbox_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 2
);
  logic                     write_req;
  logic                     read_req;
  logic [DATA_W-1:0]        data_write;
  logic [16:0]              address;
  logic [DATA_W-1:0]        data_read;
  logic                     busy;
  logic                     error;
  logic [NUM_CH-1:0]        host_out_rd;
  logic [NUM_CH*DATA_W-1:0] host_out_data;
  logic [NUM_CH-1:0]        host_out_ready;
  logic [NUM_CH-1:0]        host_in_wr;
  logic [NUM_CH*DATA_W-1:0] host_in_data;
  logic [NUM_CH-1:0]        host_in_ready;

  modport slave (
    input  write_req, read_req, data_write, address, host_out_rd, host_in_wr, host_in_data,
    output data_read, busy, error, host_out_data, host_out_ready, host_in_ready
  );

  modport master (
    output write_req, read_req, data_write, address, host_out_rd, host_in_wr, host_in_data,
    input  data_read, busy, error, host_out_data, host_out_ready, host_in_ready
  );
endinterface

// File: rtl/aux_mailbox.sv
// Multi-channel control<->host mailbox: one outbound and one inbound FIFO per channel,
// registered pop data (1-cycle latency); full pushes are dropped, empty pops leave data unchanged.
module aux_mailbox_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_pop_dat,
  output logic [AW:0]   o_cnt,
  output logic [AW:0]   o_cnt_nxt,
  output logic          o_full,
  output logic          o_empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic [DW-1:0] r_pop_dat;
  logic          w_do_push;
  logic          w_do_pop;
  logic [AW:0]   w_cnt_nxt;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_do_push && !w_do_pop) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (w_do_pop && !w_do_push) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_pop_dat <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_pop_dat <= r_mem[r_rd_ptr];
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  assign o_pop_dat = r_pop_dat;
  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;
endmodule

module aux_mailbox #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int NUM_CH     = 2,
  parameter int RD_BLOCK   = 4,
  parameter int WR_BLOCK   = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         reset,
  aux_mailbox_if.slave bus
);
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int CNT_W      = DEPTH_LOG2 + 1;
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TO_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit IN_RDY_RST = (WR_BLOCK <= DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_RD_DATA, S_WR_WAIT, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_error, w_error_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic [DATA_W-1:0] r_wdat, w_wdat_nxt;
  logic [CH_W-1:0]   r_ch, w_ch_nxt;
  logic [TO_W-1:0]   r_wait_cnt, w_wait_nxt;

  logic [CH_W-1:0]   w_req_ch;
  logic              w_req_bad;
  logic              w_stat_rd;
  logic              w_timeout;
  logic              w_push_any;
  logic              w_pop_any;
  logic [DATA_W-1:0] w_stat;

  logic [NUM_CH-1:0] r_ovf, r_unf;
  logic [NUM_CH-1:0] r_out_rdy, r_in_rdy;
  logic [NUM_CH-1:0] w_ctl_push, w_ctl_pop, w_stat_clr, w_ovf_set, w_unf_set;
  logic [NUM_CH*DATA_W-1:0] w_host_out_data;

  logic [DATA_W-1:0] w_out_rdat [NUM_CH];
  logic [DATA_W-1:0] w_in_rdat  [NUM_CH];
  logic [CNT_W-1:0]  w_out_cnt  [NUM_CH];
  logic [CNT_W-1:0]  w_in_cnt   [NUM_CH];
  logic [CNT_W-1:0]  w_out_cnt_nxt [NUM_CH];
  logic [CNT_W-1:0]  w_in_cnt_nxt  [NUM_CH];
  logic              w_out_full [NUM_CH];
  logic              w_out_empty[NUM_CH];
  logic              w_in_full  [NUM_CH];
  logic              w_in_empty [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    aux_mailbox_fifo #(.DW(DATA_W), .AW(DEPTH_LOG2)) u_out (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_ctl_push[g]),
      .i_push_dat (r_wdat),
      .i_pop      (bus.host_out_rd[g]),
      .o_pop_dat  (w_out_rdat[g]),
      .o_cnt      (w_out_cnt[g]),
      .o_cnt_nxt  (w_out_cnt_nxt[g]),
      .o_full     (w_out_full[g]),
      .o_empty    (w_out_empty[g])
    );

    aux_mailbox_fifo #(.DW(DATA_W), .AW(DEPTH_LOG2)) u_in (
      .clk        (clk),
      .reset      (reset),
      .i_push     (bus.host_in_wr[g]),
      .i_push_dat (bus.host_in_data[g*DATA_W +: DATA_W]),
      .i_pop      (w_ctl_pop[g]),
      .o_pop_dat  (w_in_rdat[g]),
      .o_cnt      (w_in_cnt[g]),
      .o_cnt_nxt  (w_in_cnt_nxt[g]),
      .o_full     (w_in_full[g]),
      .o_empty    (w_in_empty[g])
    );
  end

  // Channel range is judged on the full 16-bit index so aliases above NUM_CH are rejected.
  assign w_req_ch  = bus.address[CH_W-1:0];
  assign w_req_bad = ({16'b0, bus.address[15:0]} >= 32'(NUM_CH));
  assign w_stat_rd = (r_state == S_IDLE) && bus.read_req && bus.address[16] && !w_req_bad;
  assign w_timeout = (TIMEOUT != 0) && (r_wait_cnt == TO_W'(TIMEOUT));

  always_comb begin
    w_stat                       = '0;
    w_stat[DATA_W-1]             = r_ovf[w_req_ch];
    w_stat[DATA_W-2]             = r_unf[w_req_ch];
    w_stat[2*CNT_W-1:CNT_W]      = w_in_cnt[w_req_ch];
    w_stat[CNT_W-1:0]            = w_out_cnt[w_req_ch];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_error_nxt = r_error;
    w_rdata_nxt = r_rdata;
    w_wdat_nxt  = r_wdat;
    w_ch_nxt    = r_ch;
    w_wait_nxt  = r_wait_cnt + 1'b1;
    w_push_any  = 1'b0;
    w_pop_any   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wait_nxt = '0;
        if (bus.read_req || bus.write_req) begin
          w_ch_nxt    = w_req_ch;
          w_wdat_nxt  = bus.data_write;
          w_busy_nxt  = 1'b1;
          w_error_nxt = 1'b0;
          if (w_req_bad) begin
            w_state_nxt = S_DONE;
            w_error_nxt = 1'b1;
            w_rdata_nxt = '0;
          end else if (bus.address[16]) begin
            w_state_nxt = S_DONE;
            if (bus.read_req) begin
              w_rdata_nxt = w_stat;
            end
          end else if (bus.read_req) begin
            w_state_nxt = S_RD_WAIT;
          end else begin
            w_state_nxt = S_WR_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (!w_in_empty[r_ch]) begin
          w_pop_any   = 1'b1;
          w_state_nxt = S_RD_DATA;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_error_nxt = 1'b1;
          w_rdata_nxt = '0;
        end
      end
      S_RD_DATA: begin
        w_rdata_nxt = w_in_rdat[r_ch];
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      S_WR_WAIT: begin
        if (!w_out_full[r_ch]) begin
          w_push_any  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_error_nxt = 1'b1;
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_ctl_push      = '0;
    w_ctl_pop       = '0;
    w_stat_clr      = '0;
    w_ovf_set       = '0;
    w_unf_set       = '0;
    w_host_out_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_ctl_push[c] = w_push_any && (r_ch == CH_W'(c));
      w_ctl_pop[c]  = w_pop_any && (r_ch == CH_W'(c));
      w_stat_clr[c] = w_stat_rd && (w_req_ch == CH_W'(c));
      w_ovf_set[c]  = bus.host_in_wr[c] && w_in_full[c];
      w_unf_set[c]  = bus.host_out_rd[c] && w_out_empty[c];
      w_host_out_data[c*DATA_W +: DATA_W] = w_out_rdat[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
      r_rdata    <= '0;
      r_wdat     <= '0;
      r_ch       <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= w_busy_nxt;
      r_error    <= w_error_nxt;
      r_rdata    <= w_rdata_nxt;
      r_wdat     <= w_wdat_nxt;
      r_ch       <= w_ch_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // A host fault arriving on the same edge as a status read stays sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf     <= '0;
      r_unf     <= '0;
      r_out_rdy <= '0;
      r_in_rdy  <= {NUM_CH{IN_RDY_RST}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_ovf_set[c]) begin
          r_ovf[c] <= 1'b1;
        end else if (w_stat_clr[c]) begin
          r_ovf[c] <= 1'b0;
        end
        if (w_unf_set[c]) begin
          r_unf[c] <= 1'b1;
        end else if (w_stat_clr[c]) begin
          r_unf[c] <= 1'b0;
        end
        r_out_rdy[c] <= ({{(32-CNT_W){1'b0}}, w_out_cnt_nxt[c]} >= 32'(RD_BLOCK));
        r_in_rdy[c]  <= ((32'(DEPTH) - {{(32-CNT_W){1'b0}}, w_in_cnt_nxt[c]}) >= 32'(WR_BLOCK));
      end
    end
  end

  assign bus.data_read      = r_rdata;
  assign bus.busy           = r_busy;
  assign bus.error          = r_error;
  assign bus.host_out_data  = w_host_out_data;
  assign bus.host_out_ready = r_out_rdy;
  assign bus.host_in_ready  = r_in_rdy;
endmodule

// File: tb/tb_aux_mailbox.sv
// Directed bench for aux_mailbox with NUM_CH=2, depth 16, TIMEOUT=16.
module tb_aux_mailbox;
  localparam int K_CWR = 0, K_CRD = 1, K_HPUSH = 2, K_HPOP = 3;
  localparam int NV = 18;

  typedef struct {
    int          kind;
    logic [16:0] addr;
    logic [31:0] dat;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_busy;
  } vec_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  vec_t vecs [NV];

  aux_mailbox_if #(.DATA_W(32), .NUM_CH(2)) mb ();

  aux_mailbox #(
    .DATA_W(32), .DEPTH_LOG2(4), .NUM_CH(2),
    .RD_BLOCK(4), .WR_BLOCK(8), .TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic ctl_op(input bit rd, input bit wr, input logic [16:0] addr,
                        input logic [31:0] d, output int cyc);
    @(negedge clk);
    mb.read_req   = rd;
    mb.write_req  = wr;
    mb.address    = addr;
    mb.data_write = d;
    @(negedge clk);
    mb.read_req  = 1'b0;
    mb.write_req = 1'b0;
    cyc = 0;
    while (mb.busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic host_push(input int ch, input logic [31:0] d);
    @(negedge clk);
    mb.host_in_wr[ch]             = 1'b1;
    mb.host_in_data[ch*32 +: 32]  = d;
    @(negedge clk);
    mb.host_in_wr = '0;
  endtask

  task automatic host_pop(input int ch);
    @(negedge clk);
    mb.host_out_rd[ch] = 1'b1;
    @(negedge clk);
    mb.host_out_rd = '0;
  endtask

  task automatic status(input int ch, input logic [31:0] exp, input string nm);
    int cyc;
    ctl_op(1'b1, 1'b0, 17'h10000 | 17'(ch), 32'h0, cyc);
    chk({nm, " busy"}, 64'(cyc), 64'd1);
    chk({nm, " data"}, 64'(mb.data_read), 64'(exp));
  endtask

  initial begin
    int cyc;
    n_chk  = 0;
    n_pass = 0;
    vecs[0]  = '{K_CWR,   17'h00001, 32'hDEADBEEF, 32'h0,          1'b0, 1};
    vecs[1]  = '{K_HPOP,  17'h00001, 32'h0,        32'hDEADBEEF,   1'b0, 0};
    vecs[2]  = '{K_HPUSH, 17'h00000, 32'h11,       32'h1,          1'b0, 0};
    vecs[3]  = '{K_HPUSH, 17'h00000, 32'h22,       32'h1,          1'b0, 0};
    vecs[4]  = '{K_CRD,   17'h00000, 32'h0,        32'h11,         1'b0, 2};
    vecs[5]  = '{K_CRD,   17'h00000, 32'h0,        32'h22,         1'b0, 2};
    vecs[6]  = '{K_CRD,   17'h00000, 32'h0,        32'h0,          1'b1, 18};
    vecs[7]  = '{K_CRD,   17'h10000, 32'h0,        32'h0,          1'b0, 1};
    vecs[8]  = '{K_HPOP,  17'h00000, 32'h0,        32'h0,          1'b0, 0};
    vecs[9]  = '{K_CRD,   17'h10000, 32'h0,        32'h40000000,   1'b0, 1};
    vecs[10] = '{K_CRD,   17'h00002, 32'h0,        32'h0,          1'b1, 1};
    vecs[11] = '{K_CRD,   17'h10000, 32'h0,        32'h0,          1'b0, 1};
    vecs[12] = '{K_CWR,   17'h00001, 32'h0000000A, 32'h0,          1'b0, 1};
    vecs[13] = '{K_CWR,   17'h10001, 32'hFFFFFFFF, 32'h0,          1'b0, 1};
    vecs[14] = '{K_CRD,   17'h10001, 32'h0,        32'h00000001,   1'b0, 1};
    vecs[15] = '{K_HPOP,  17'h00001, 32'h0,        32'h0000000A,   1'b0, 0};
    vecs[16] = '{K_CWR,   17'h00002, 32'h5,        32'h0,          1'b1, 1};
    vecs[17] = '{K_CRD,   17'h10002, 32'h0,        32'h0,          1'b1, 1};

    reset         = 1'b1;
    mb.write_req  = 1'b0;
    mb.read_req   = 1'b0;
    mb.data_write = '0;
    mb.address    = '0;
    mb.host_out_rd  = '0;
    mb.host_in_wr   = '0;
    mb.host_in_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst busy",        64'(mb.busy),           64'd0);
    chk("rst error",       64'(mb.error),          64'd0);
    chk("rst data_read",   64'(mb.data_read),      64'd0);
    chk("rst out_data",    64'(mb.host_out_data),  64'd0);
    chk("rst out_ready",   64'(mb.host_out_ready), 64'd0);
    chk("rst in_ready",    64'(mb.host_in_ready),  64'd3);

    for (int i = 0; i < NV; i++) begin
      int ch;
      ch = int'(vecs[i].addr[0]);
      case (vecs[i].kind)
        K_CWR, K_CRD: begin
          ctl_op(vecs[i].kind == K_CRD, vecs[i].kind == K_CWR, vecs[i].addr, vecs[i].dat, cyc);
          chk($sformatf("v%0d busy_cycles", i), 64'(cyc),          64'(vecs[i].exp_busy));
          chk($sformatf("v%0d error", i),       64'(mb.error),     64'(vecs[i].exp_err));
          chk($sformatf("v%0d data_read", i),   64'(mb.data_read), 64'(vecs[i].exp_dat));
        end
        K_HPUSH: begin
          host_push(ch, vecs[i].dat);
          chk($sformatf("v%0d in_ready", i), 64'(mb.host_in_ready[ch]), 64'(vecs[i].exp_dat[0]));
        end
        default: begin
          host_pop(ch);
          chk($sformatf("v%0d out_data", i), 64'(mb.host_out_data[ch*32 +: 32]), 64'(vecs[i].exp_dat));
        end
      endcase
    end

    // Inbound overflow on ch0: 17th word dropped, ready drops once free < 8.
    for (int i = 0; i < 17; i++) begin
      host_push(0, 32'h100 + 32'(i));
      chk($sformatf("ovf in_ready after push %0d", i), 64'(mb.host_in_ready[0]),
          64'(((i + 1 > 16) ? 16 : i + 1) <= 8));
    end
    status(0, 32'h80000200, "ovf status1");
    status(0, 32'h00000200, "ovf status2");
    for (int i = 0; i < 16; i++) begin
      ctl_op(1'b1, 1'b0, 17'h0, 32'h0, cyc);
      chk($sformatf("drain %0d", i), 64'(mb.data_read), 64'(32'h100 + 32'(i)));
    end

    // Outbound block-ready on ch1, then a pop coinciding with a control push.
    for (int i = 0; i < 4; i++) begin
      ctl_op(1'b0, 1'b1, 17'h1, 32'h200 + 32'(i), cyc);
      chk($sformatf("out_ready after write %0d", i), 64'(mb.host_out_ready[1]), 64'(i >= 3));
    end
    @(negedge clk);
    mb.write_req  = 1'b1;
    mb.address    = 17'h1;
    mb.data_write = 32'h300;
    @(negedge clk);
    mb.write_req      = 1'b0;
    mb.host_out_rd[1] = 1'b1;
    @(negedge clk);
    mb.host_out_rd = '0;
    chk("simul busy",      64'(mb.busy),                  64'd0);
    chk("simul out_ready", 64'(mb.host_out_ready[1]),     64'd1);
    chk("simul out_data",  64'(mb.host_out_data[63:32]),  64'h200);
    status(1, 32'h00000004, "simul status");

    // Reset in the middle of a read wait.
    @(negedge clk);
    mb.read_req = 1'b1;
    mb.address  = 17'h0;
    @(negedge clk);
    mb.read_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid busy before reset", 64'(mb.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid rst busy",      64'(mb.busy),           64'd0);
    chk("mid rst error",     64'(mb.error),          64'd0);
    chk("mid rst data_read", 64'(mb.data_read),      64'd0);
    chk("mid rst out_data",  64'(mb.host_out_data),  64'd0);
    chk("mid rst out_ready", 64'(mb.host_out_ready), 64'd0);
    chk("mid rst in_ready",  64'(mb.host_in_ready),  64'd3);
    status(1, 32'h0, "post rst status");

    // read_req and write_req together: the read is served, the write dropped.
    host_push(1, 32'h55);
    ctl_op(1'b1, 1'b1, 17'h1, 32'h77, cyc);
    chk("both busy_cycles", 64'(cyc),          64'd2);
    chk("both error",       64'(mb.error),     64'd0);
    chk("both data_read",   64'(mb.data_read), 64'h55);
    status(1, 32'h0, "both status");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
